// File: rtl/paddle_controller.sv
// paddle_controller
//   Turns synchronised up/down button levels into the Pong paddle's top line.
//   Each button passes a stability filter; the filtered pair selects an
//   UP/DOWN/IDLE state, and the paddle moves once per frame tick with
//   press-and-hold acceleration, clamped to 0..Y_MAX.
// Ports
//   i_clock      system clock
//   i_reset_n    asynchronous active-low reset
//   i_btn_up     synchronised up-button level (1 = pressed)
//   i_btn_down   synchronised down-button level (1 = pressed)
//   i_frame_tick one-cycle pulse per frame
//   o_paddle_y   paddle top line, 0..Y_MAX
//   o_at_top     paddle at line 0
//   o_at_bottom  paddle at Y_MAX
//   o_moving     state is UP or DOWN
module paddle_controller #(
   parameter int unsigned STABLE_CYCLES = 1000000,
   parameter int unsigned SCREEN_H      = 480,
   parameter int unsigned PADDLE_H      = 80,
   parameter int unsigned Y_INIT        = 200,
   parameter int unsigned SPEED_MIN     = 2,
   parameter int unsigned SPEED_MAX     = 8,
   parameter int unsigned ACCEL_FRAMES  = 4
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_frame_tick,
   output logic [9:0] o_paddle_y,
   output logic       o_at_top,
   output logic       o_at_bottom,
   output logic       o_moving
);

   localparam int unsigned YMax = SCREEN_H - PADDLE_H;
   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned FrmW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
   localparam int unsigned SpdW = $clog2(SPEED_MAX + 1);

   localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
   localparam logic [FrmW-1:0] FrmLast = FrmW'(ACCEL_FRAMES - 1);
   localparam logic [SpdW-1:0] SpdMin  = SpdW'(SPEED_MIN);
   localparam logic [SpdW-1:0] SpdMax  = SpdW'(SPEED_MAX);
   localparam logic [10:0]     YMax11  = 11'(YMax);
   localparam logic [9:0]      YMax10  = 10'(YMax);
   localparam logic [9:0]      YInit10 = 10'(Y_INIT);

   typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

   state_e          state_q, state_d;
   logic [1:0]      filt_q, filt_d;      // bit 0 = up, bit 1 = down
   logic [CntW-1:0] cnt_q [2];
   logic [CntW-1:0] cnt_d [2];
   logic [9:0]      y_q, y_d;
   logic [SpdW-1:0] speed_q, speed_d;
   logic [FrmW-1:0] frm_q, frm_d;

   logic [1:0]  raw;
   logic [10:0] y_ext, spd_ext, dn_sum;

   assign raw     = {i_btn_down, i_btn_up};
   assign y_ext   = {1'b0, y_q};
   assign spd_ext = 11'(speed_q);
   assign dn_sum  = y_ext + spd_ext;

   // Stability filter: accept a new level only after CntLast+1 consecutive mismatches.
   always_comb begin
      filt_d = filt_q;
      for (int b = 0; b < 2; b++) begin
         cnt_d[b] = '0;
         if (raw[b] != filt_q[b]) begin
            if (cnt_q[b] == CntLast) begin
               filt_d[b] = raw[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CntW'(1);
            end
         end
      end
   end

   always_comb begin
      unique case (filt_q)
         2'b01:   state_d = StUp;
         2'b10:   state_d = StDown;
         default: state_d = StIdle;
      endcase
   end

   // Motion uses the registered state, so a tick coinciding with a state change
   // still moves in the old direction.
   always_comb begin
      y_d = y_q;
      if (i_frame_tick) begin
         case (state_q)
            StUp:    y_d = (y_ext < spd_ext) ? '0 : 10'(y_ext - spd_ext);
            StDown:  y_d = (dn_sum > YMax11) ? YMax10 : 10'(dn_sum);
            default: y_d = y_q;
         endcase
      end
   end

   // A state change reloads speed and frame count ahead of any acceleration.
   always_comb begin
      speed_d = speed_q;
      frm_d   = frm_q;
      if (state_d != state_q) begin
         speed_d = SpdMin;
         frm_d   = '0;
      end else if (i_frame_tick && (state_q != StIdle)) begin
         if (frm_q == FrmLast) begin
            frm_d = '0;
            if (speed_q < SpdMax) begin
               speed_d = speed_q + SpdW'(1);
            end
         end else begin
            frm_d = frm_q + FrmW'(1);
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= StIdle;
         filt_q  <= '0;
         cnt_q   <= '{default: '0};
         y_q     <= YInit10;
         speed_q <= SpdMin;
         frm_q   <= '0;
      end else begin
         state_q <= state_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         speed_q <= speed_d;
         frm_q   <= frm_d;
      end
   end

   assign o_paddle_y  = y_q;
   assign o_at_top    = (y_q == '0);
   assign o_at_bottom = (y_q == YMax10);
   assign o_moving    = (state_q != StIdle);

endmodule

// File: tb/tb_paddle_controller.sv
module tb_paddle_controller;

   localparam int STABLE = 4;
   localparam int ACCEL  = 4;
   localparam int SPMIN  = 2;
   localparam int SPMAX  = 8;
   localparam int YMAX   = 400;
   localparam int YINIT  = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       up = 1'b0;
   logic       dn = 1'b0;
   logic       tick = 1'b0;
   logic [9:0] paddle_y;
   logic       at_top, at_bottom, moving;

   paddle_controller #(
      .STABLE_CYCLES(STABLE),
      .SCREEN_H     (480),
      .PADDLE_H     (80),
      .Y_INIT       (YINIT),
      .SPEED_MIN    (SPMIN),
      .SPEED_MAX    (SPMAX),
      .ACCEL_FRAMES (ACCEL)
   ) dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_btn_up    (up),
      .i_btn_down  (dn),
      .i_frame_tick(tick),
      .o_paddle_y  (paddle_y),
      .o_at_top    (at_top),
      .o_at_bottom (at_bottom),
      .o_moving    (moving)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] y;
      logic       mv;
      logic       top;
      logic       bot;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   errors  = 0;

   // Reference model: direction -1 = up (y shrinks), +1 = down, 0 = idle.
   int m_y, m_dir, m_speed, m_frames;
   int m_f[2];
   int m_cnt[2];

   function automatic void model_reset();
      m_y = YINIT; m_dir = 0; m_speed = SPMIN; m_frames = 0;
      for (int b = 0; b < 2; b++) begin
         m_f[b] = 0; m_cnt[b] = 0;
      end
   endfunction

   function automatic void model_step(input int u, input int d, input int t);
      int raw[2];
      int tgt;
      raw[0] = u; raw[1] = d;
      if (m_f[0] == 1 && m_f[1] == 0) tgt = -1;
      else if (m_f[1] == 1 && m_f[0] == 0) tgt = 1;
      else tgt = 0;
      for (int b = 0; b < 2; b++) begin
         if (raw[b] != m_f[b]) begin
            m_cnt[b]++;
            if (m_cnt[b] == STABLE) begin
               m_f[b] = raw[b]; m_cnt[b] = 0;
            end
         end else begin
            m_cnt[b] = 0;
         end
      end
      if (t != 0) begin
         if (m_dir < 0) m_y = (m_y < m_speed) ? 0 : m_y - m_speed;
         if (m_dir > 0) m_y = (m_y + m_speed > YMAX) ? YMAX : m_y + m_speed;
      end
      if (tgt != m_dir) begin
         m_speed = SPMIN; m_frames = 0;
      end else if (t != 0 && m_dir != 0) begin
         m_frames++;
         if (m_frames == ACCEL) begin
            m_frames = 0;
            if (m_speed < SPMAX) m_speed++;
         end
      end
      m_dir = tgt;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle at the falling edge, queue the model's view of the next edge.
   task automatic step(input int u, input int d, input int t);
      exp_t e;
      @(negedge clk);
      up = u[0]; dn = d[0]; tick = t[0];
      model_step(u, d, t);
      e.y   = 10'(m_y);
      e.mv  = (m_dir != 0);
      e.top = (m_y == 0);
      e.bot = (m_y == YMAX);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("sb_y", int'(paddle_y), int'(e.y));
            check("sb_moving", int'(moving), int'(e.mv));
            check("sb_at_top", int'(at_top), int'(e.top));
            check("sb_at_bottom", int'(at_bottom), int'(e.bot));
         end
      end
   end

   initial begin : stimulus
      int t3[12] = '{198, 196, 194, 192, 189, 186, 183, 180, 176, 172, 168, 164};
      int y0;
      int ru, rd;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("reset_y", int'(paddle_y), YINIT);
      check("reset_moving", int'(moving), 0);
      check("reset_at_top", int'(at_top), 0);
      check("reset_at_bottom", int'(at_bottom), 0);

      // Ticks with no buttons: nothing moves.
      for (int i = 0; i < 10; i++) step(0, 0, (i % 3 == 0) ? 1 : 0);
      check("idle_y", int'(paddle_y), YINIT);
      check("idle_moving", int'(moving), 0);

      // Glitch shorter than the filter window is rejected.
      repeat (2) step(1, 0, 0);
      repeat (3) step(0, 0, 0);
      check("glitch_rejected", int'(moving), 0);
      repeat (4) step(1, 0, 0);
      check("filter_edge4", int'(moving), 0);
      step(1, 0, 0);
      check("filter_edge5", int'(moving), 1);

      // Held up: acceleration profile.
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 1);
         check("accel_y", int'(paddle_y), t3[i]);
         step(1, 0, 0);
      end

      // Clamp at bottom then at top.
      for (int i = 0; i < 160; i++) step(0, 1, i % 2);
      check("clamp_bottom_y", int'(paddle_y), YMAX);
      check("clamp_at_bottom", int'(at_bottom), 1);
      check("clamp_bottom_moving", int'(moving), 1);
      for (int i = 0; i < 200; i++) step(1, 0, i % 2);
      check("clamp_top_y", int'(paddle_y), 0);
      check("clamp_at_top", int'(at_top), 1);

      // Both held: idle, then release up and move down at minimum speed.
      repeat (10) step(1, 1, 0);
      check("both_moving", int'(moving), 0);
      y0 = int'(paddle_y);
      repeat (6) step(1, 1, 1);
      check("both_hold_y", int'(paddle_y), y0);
      repeat (4) step(0, 1, 0);
      check("release_edge4", int'(moving), 0);
      step(0, 1, 0);
      check("release_edge5", int'(moving), 1);
      step(0, 1, 1);
      check("release_speed", int'(paddle_y), y0 + SPMIN);

      // Randomized held levels and ticks.
      ru = 0; rd = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) ru = 1 - ru;
         if ($urandom_range(0, 39) == 0) rd = 1 - rd;
         step(ru, rd, ($urandom_range(0, 5) == 0) ? 1 : 0);
      end

      // Asynchronous reset mid-motion.
      repeat (12) step(0, 1, 1);
      check("pre_reset_moving", int'(moving), 1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_reset_y", int'(paddle_y), YINIT);
      check("async_reset_moving", int'(moving), 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      step(0, 1, 1);
      check("post_reset_no_move", int'(paddle_y), YINIT);
      repeat (12) step(0, 1, i_tick_pattern());

      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   function automatic int i_tick_pattern();
      return ($urandom_range(0, 2) == 0) ? 1 : 0;
   endfunction

endmodule
